// File: rtl/fir_coeff_ce_ctrl.sv
// Sample clock-enable generator and double-buffered coefficient bank for the FIR cores.
// The shadow bank moves to the active bank in one step, on the edge that raises o_ce.
`timescale 1ns/1ps
module fir_coeff_ce_ctrl #(
  parameter int N_TAPS  = 9,
  parameter int COEFF_W = 32,
  parameter int ADDR_W  = 6
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [31:0]                 i32_prescaler,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic signed [COEFF_W-1:0]   is_wr_data,
  input  logic                        i_commit,
  output logic                        o_ce,
  output logic [N_TAPS*COEFF_W-1:0]   os_coeff,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_addr_err
);

  typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;

  localparam logic [31:0] N_TAPS_U = 32'(N_TAPS);

  state_t                      state_q, state_d;
  logic [31:0]                 cnt_q, period_q, period_eff;
  logic [N_TAPS*COEFF_W-1:0]   shadow_q;
  logic                        tick, swap, wr_fire;
  logic [31:0]                 addr_u;

  // Prescaler values 0 and 1 both mean a tick every cycle.
  assign period_eff = (period_q == 32'd0) ? 32'd1 : period_q;
  assign tick       = (cnt_q == period_eff - 32'd1);

  assign o_wr_ready = (state_q == IDLE);
  assign o_busy     = (state_q == PENDING);
  assign wr_fire    = i_wr_valid && o_wr_ready;
  assign addr_u     = 32'(i_wr_addr);
  assign swap       = (state_q == PENDING) && tick;

  always_comb begin
    // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_commit) state_d = PENDING;
      PENDING: if (tick)     state_d = SWAP;
      SWAP:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Period tracks the input while reset is held, so it holds the value present at release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      period_q <= i32_prescaler;
      o_ce     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      o_ce <= tick;
      if (tick) begin
        cnt_q    <= '0;
        period_q <= i32_prescaler;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      o_done     <= 1'b0;
      o_addr_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_done     <= swap;
      o_addr_err <= wr_fire && (addr_u >= N_TAPS_U);
    end
  end

  // NOTE: both coefficient banks are reset on purpose; a reset must leave the filter with all-zero taps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q <= '0;
      os_coeff <= '0;
    end else begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (wr_fire && (addr_u == 32'(k)))
          shadow_q[k*COEFF_W +: COEFF_W] <= is_wr_data;
      end
      if (swap)
        os_coeff <= shadow_q;
    end
  end

endmodule
